complex_mult_scheduler: RTL and testbench

Sequencer that shares one 4x4 unsigned multiplier across the four partial products of a complex multiply: (ar + j·ai)·(br + j·bi). It accepts one operand set per start, issues ar·br, ai·bi, ar·bi and ai·br to the shared multiplier through its start/ready handshake, and accumulates the products. It then presents res_re = ar·br − ai·bi and res_im = ar·bi + ai·br. It sits between the complex-multiplier top level and the single 4x4 multiplier instance.

---
 rtl/complex_mult_scheduler.sv | 139 +++++++++++++
 tb/tb_complex_mult_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mult_scheduler.sv
`default_nettype none
// ============================================================================
//  complex_mult_scheduler
//  Time-shares one 4x4 multiplier across the four partial products of a
//  complex multiply and accumulates res_re / res_im.
//  Revision: 1.0
// ============================================================================
module complex_mult_scheduler #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] ar,
  input  logic [3:0] ai,
  input  logic [3:0] br,
  input  logic [3:0] bi,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [9:0] res_re,
  output logic [9:0] res_im,
  output logic [3:0] mul_A,
  output logic [3:0] mul_B,
  output logic       mul_start,
  input  logic [7:0] mul_res,
  input  logic       mul_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_ACK   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              TW       = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0]   ACK_LAST = TW'(ACK_TIMEOUT - 1);

  logic [2:0]    state;
  logic [1:0]    k;
  logic [3:0]    op_ar, op_ai, op_br, op_bi;
  logic [9:0]    acc_re, acc_im;
  logic [TW-1:0] ack_cnt;
  logic [3:0]    sel_a, sel_b;
  logic [9:0]    prod10;

  assign prod10    = {2'b00, mul_res};
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mul_start = (state == S_ISSUE);

  // Operand pair for the product currently in flight; k only changes at capture.
  always_comb begin
    sel_a = op_ar;
    sel_b = op_br;
    case (k)
      2'd0: begin sel_a = op_ar; sel_b = op_br; end
      2'd1: begin sel_a = op_ai; sel_b = op_bi; end
      2'd2: begin sel_a = op_ar; sel_b = op_bi; end
      default: begin sel_a = op_ai; sel_b = op_br; end
    endcase
  end

  assign mul_A = (state == S_IDLE) ? 4'd0 : sel_a;
  assign mul_B = (state == S_IDLE) ? 4'd0 : sel_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      k       <= 2'd0;
      op_ar   <= 4'd0;
      op_ai   <= 4'd0;
      op_br   <= 4'd0;
      op_bi   <= 4'd0;
      acc_re  <= 10'd0;
      acc_im  <= 10'd0;
      ack_cnt <= '0;
      err     <= 1'b0;
      res_re  <= 10'd0;
      res_im  <= 10'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_ar  <= ar;
            op_ai  <= ai;
            op_br  <= br;
            op_bi  <= bi;
            acc_re <= 10'd0;
            acc_im <= 10'd0;
            k      <= 2'd0;
            err    <= 1'b0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ack_cnt <= '0;
          state   <= S_ACK;
        end
        S_ACK: begin
          // A high ready here is the previous idle level, never a result.
          if (!mul_ready) begin
            state <= S_RUN;
          end else if (ack_cnt == ACK_LAST) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (mul_ready) begin
            case (k)
              2'd0:    acc_re <= acc_re + prod10;
              2'd1:    acc_re <= acc_re - prod10;
              default: acc_im <= acc_im + prod10;
            endcase
            if (k == 2'd3) begin
              state <= S_DONE;
            end else begin
              k     <= k + 2'd1;
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          if (!err) begin
            res_re <= acc_re;
            res_im <= acc_im;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_complex_mult_scheduler.sv
`default_nettype none
// ============================================================================
//  tb_complex_mult_scheduler
//  Directed vectors against a latency-programmable multiplier model.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_complex_mult_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] ar = 4'd0, ai = 4'd0, br = 4'd0, bi = 4'd0;
  logic       busy, done, err, mul_start;
  logic [9:0] res_re, res_im;
  logic [3:0] mul_A, mul_B;
  logic [7:0] mul_res;
  logic       mul_ready;

  always #5 clk = ~clk;

  complex_mult_scheduler #(.ACK_TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ar        (ar),
    .ai        (ai),
    .br        (br),
    .bi        (bi),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .res_re    (res_re),
    .res_im    (res_im),
    .mul_A     (mul_A),
    .mul_B     (mul_B),
    .mul_start (mul_start),
    .mul_res   (mul_res),
    .mul_ready (mul_ready)
  );

  // Multiplier model: ready drops after mul_start, stays low n_lat cycles.
  int         n_lat = 5;
  logic       stuck = 1'b0;
  int         rem;
  logic       inflight;
  logic [3:0] lat_a, lat_b;
  logic [7:0] prod;

  assign mul_res = prod;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_ready <= 1'b1;
      rem       <= 0;
      inflight  <= 1'b0;
      prod      <= 8'd0;
      lat_a     <= 4'd0;
      lat_b     <= 4'd0;
    end else if (mul_start && !stuck) begin
      mul_ready <= 1'b0;
      rem       <= n_lat;
      prod      <= {4'd0, mul_A} * {4'd0, mul_B};
      lat_a     <= mul_A;
      lat_b     <= mul_B;
      inflight  <= 1'b1;
    end else if (!mul_ready) begin
      rem <= rem - 1;
      if (rem <= 1) mul_ready <= 1'b1;
    end else if (inflight) begin
      inflight <= 1'b0;
    end
  end

  int         nstarts = 0;
  logic [7:0] pairs [64];
  always @(posedge clk) begin
    if (rst && mul_start) begin
      pairs[nstarts % 64] = {mul_A, mul_B};
      nstarts = nstarts + 1;
    end
  end

  int   stab_err = 0, dbl_done = 0, dbl_start = 0;
  logic prev_done = 1'b0, prev_start = 1'b0;
  always @(negedge clk) begin
    if (inflight && ({mul_A, mul_B} !== {lat_a, lat_b})) stab_err = stab_err + 1;
    if (done && prev_done) dbl_done = dbl_done + 1;
    if (mul_start && prev_start) dbl_start = dbl_start + 1;
    prev_done  = done;
    prev_start = mul_start;
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] ar, ai, br, bi;
    int         n;
    logic [9:0] re, im;
    int         done_cyc;
  } vec_t;

  vec_t vecs[6];

  // Called at the negedge of the IDLE cycle that becomes cycle 0; returns in cycle 1.
  task automatic launch(input vec_t v, input bit hold);
    ar = v.ar; ai = v.ai; br = v.br; bi = v.bi;
    n_lat = v.n;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = -1;
    for (int c = from; c < from + 300; c++) begin
      if (done) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, s0, e0;
    s0 = nstarts;
    e0 = stab_err;
    launch(v, 1'b0);
    wait_done(1, cyc);
    check("done_cycle", cyc, v.done_cyc);
    check("err_at_done", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("res_re", {22'd0, res_re}, {22'd0, v.re});
    check("res_im", {22'd0, res_im}, {22'd0, v.im});
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("mul_start_count", nstarts - s0, 4);
    check("pair_order",
          {pairs[s0 % 64], pairs[(s0 + 1) % 64], pairs[(s0 + 2) % 64], pairs[(s0 + 3) % 64]},
          {v.ar, v.br, v.ai, v.bi, v.ar, v.bi, v.ai, v.br});
    check("pair_stable", stab_err - e0, 0);
  endtask

  initial begin
    int cyc, s0;
    vecs[0] = '{4'd3,  4'd2,  4'd5,  4'd7,  5,  10'd1,   10'h01F, 29};
    vecs[1] = '{4'd15, 4'd15, 4'd15, 4'd15, 5,  10'd0,   10'h1C2, 29};
    vecs[2] = '{4'd0,  4'd15, 4'd0,  4'd15, 5,  10'h31F, 10'd0,   29};
    vecs[3] = '{4'd9,  4'd4,  4'd6,  4'd11, 1,  10'd10,  10'd123, 13};
    vecs[4] = '{4'd7,  4'd13, 4'd12, 4'd2,  12, 10'd58,  10'd170, 57};
    vecs[5] = '{4'd1,  4'd14, 4'd2,  4'd15, 3,  10'h330, 10'd43,  21};

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {8'd0, busy, done, err, mul_start, mul_A, mul_B, res_re, res_im},
          32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // start held high: one op per done, next accepted only in the cycle after done
    s0 = nstarts;
    launch(vecs[0], 1'b1);
    wait_done(1, cyc);
    check("held_done_cycle", cyc, 29);
    @(negedge clk);
    check("held_idle_busy", {31'd0, busy}, 32'd0);
    check("held_idle_mstart", {31'd0, mul_start}, 32'd0);
    @(negedge clk);
    check("held_reissue", {30'd0, busy, mul_start}, 32'd3);
    check("held_start_count", nstarts - s0, 4);
    start = 1'b0;
    wait_done(1, cyc);
    check("held2_done_cycle", cyc, 29);
    @(negedge clk);
    check("held2_res", {12'd0, res_re, res_im}, {12'd0, 10'd1, 10'h01F});

    // ready stuck high: abort 16 cycles after ISSUE (cycle 1), results kept
    stuck = 1'b1;
    s0 = nstarts;
    launch(vecs[1], 1'b0);
    wait_done(1, cyc);
    check("timeout_done_cycle", cyc, 17);
    check("timeout_err", {31'd0, err}, 32'd1);
    check("timeout_starts", nstarts - s0, 1);
    @(negedge clk);
    check("timeout_res_kept", {12'd0, res_re, res_im}, {12'd0, 10'd1, 10'h01F});
    repeat (3) @(negedge clk);
    check("err_held", {31'd0, err}, 32'd1);
    stuck = 1'b0;
    launch(vecs[0], 1'b0);
    check("err_cleared", {31'd0, err}, 32'd0);
    wait_done(1, cyc);
    check("recover_done_cycle", cyc, 29);
    @(negedge clk);
    check("recover_res", {12'd0, res_re, res_im}, {12'd0, 10'd1, 10'h01F});

    // reset during RUN of product 2 (cycles 17..21 with N=5)
    launch(vecs[1], 1'b0);
    repeat (17) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_reset_outputs",
          {8'd0, busy, done, err, mul_start, mul_A, mul_B, res_re, res_im},
          32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_vec(vecs[0]);

    check("no_double_done", dbl_done, 0);
    check("no_double_mul_start", dbl_start, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
